// File: rtl/rib_responder_pkg.sv
// Shared RIB definitions: bus widths, slave index field, slave count and
// the responder's state encodings.
package rib_responder_pkg;

  localparam int INST_ADDR_BUS  = 32;
  localparam int INST_DATA_BUS  = 32;

  localparam int RIB_NUM_SLAVES = 4;

  // Slave index field RIB_SLAVE_IDX = addr[31:28]
  localparam int RIB_IDX_HI     = 31;
  localparam int RIB_IDX_LO     = 28;
  localparam int RIB_IDX_W      = RIB_IDX_HI - RIB_IDX_LO + 1;

  typedef enum logic [1:0] {
    S_CORE    = 2'd0,
    S_DBG     = 2'd1,
    S_DBG_RSP = 2'd2
  } rib_state_e;

endpackage

// File: rtl/rib_addr_decode.sv
// RIB address decode: slave index field to one-hot slave select plus an
// unmapped flag. Purely combinational.
//   i_idx      : addr[31:28] of the access
//   o_sel      : one-hot slave select, all zero when unmapped
//   o_unmapped : index has no slave behind it
module rib_addr_decode
  import rib_responder_pkg::*;
#(
  parameter int NUM_SLAVES = RIB_NUM_SLAVES
) (
  input  logic [RIB_IDX_W-1:0]  i_idx,
  output logic [NUM_SLAVES-1:0] o_sel,
  output logic                  o_unmapped
);

  always_comb begin
    o_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      o_sel[i] = (int'(i_idx) == i);
    end
  end

  assign o_unmapped = (int'(i_idx) >= NUM_SLAVES);

endmodule

// File: rtl/rib_responder.sv
// RIB responder: slave side of the RIB bus. Arbitrates the core read and
// write channels and a debug master onto NUM_SLAVES synchronous slaves.
//   clk, rst_n            : clock, async active-low reset
//   core_rd_*             : core read request, registered read data
//   core_wr_*             : core write request
//   rib_hold_o            : stall request to the core
//   dbg_*                 : debug master request / ack / read data
//   s_*                   : shared slave bus, one-hot select
//   bus_err_o             : pulse on an access to an unmapped index
//
// state     | meaning
// S_CORE    | core owns the bus
// S_DBG     | latched debug access is issued
// S_DBG_RSP | debug ack and read data returned
module rib_responder
  import rib_responder_pkg::*;
#(
  parameter int NUM_SLAVES = RIB_NUM_SLAVES
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              core_rd_req_i,
  input  logic [INST_ADDR_BUS-1:0]          core_rd_addr_i,
  output logic [INST_DATA_BUS-1:0]          core_rd_data_o,
  input  logic                              core_wr_req_i,
  input  logic                              core_wr_en_i,
  input  logic [INST_ADDR_BUS-1:0]          core_wr_addr_i,
  input  logic [INST_DATA_BUS-1:0]          core_wr_data_i,
  output logic                              rib_hold_o,
  input  logic                              dbg_req_i,
  input  logic                              dbg_we_i,
  input  logic [INST_ADDR_BUS-1:0]          dbg_addr_i,
  input  logic [INST_DATA_BUS-1:0]          dbg_wdata_i,
  output logic                              dbg_ack_o,
  output logic [INST_DATA_BUS-1:0]          dbg_rdata_o,
  output logic [NUM_SLAVES-1:0]             s_sel_o,
  output logic                              s_we_o,
  output logic [INST_ADDR_BUS-1:0]          s_addr_o,
  output logic [INST_DATA_BUS-1:0]          s_wdata_o,
  input  logic [NUM_SLAVES*INST_DATA_BUS-1:0] s_rdata_i,
  output logic                              bus_err_o
);

  rib_state_e r_state, w_state_nxt;

  logic [NUM_SLAVES-1:0]    w_rd_sel, w_wr_sel, w_dbg_sel;
  logic                     w_rd_unm, w_wr_unm, w_dbg_unm;
  logic                     w_wr_vld, w_rd_vld, w_conflict;
  logic                     w_rd_issue, w_dbg_grant;
  logic [INST_DATA_BUS-1:0] w_rd_data, w_dbg_data;

  logic                     r_rd_vld;
  logic [NUM_SLAVES-1:0]    r_rd_sel;
  logic [INST_DATA_BUS-1:0] r_rd_last;
  logic                     r_dbg_we, r_dbg_unm;
  logic [NUM_SLAVES-1:0]    r_dbg_sel;
  logic [INST_ADDR_BUS-1:0] r_dbg_addr;
  logic [INST_DATA_BUS-1:0] r_dbg_wdata;

  rib_addr_decode #(.NUM_SLAVES(NUM_SLAVES)) u_dec_rd (
    .i_idx      (core_rd_addr_i[RIB_IDX_HI:RIB_IDX_LO]),
    .o_sel      (w_rd_sel),
    .o_unmapped (w_rd_unm)
  );

  rib_addr_decode #(.NUM_SLAVES(NUM_SLAVES)) u_dec_wr (
    .i_idx      (core_wr_addr_i[RIB_IDX_HI:RIB_IDX_LO]),
    .o_sel      (w_wr_sel),
    .o_unmapped (w_wr_unm)
  );

  rib_addr_decode #(.NUM_SLAVES(NUM_SLAVES)) u_dec_dbg (
    .i_idx      (dbg_addr_i[RIB_IDX_HI:RIB_IDX_LO]),
    .o_sel      (w_dbg_sel),
    .o_unmapped (w_dbg_unm)
  );

  assign w_wr_vld   = core_wr_req_i & core_wr_en_i;
  assign w_rd_vld   = core_rd_req_i;
  // Unmapped indices select nothing, so they never count as a conflict.
  assign w_conflict = w_wr_vld & w_rd_vld & (|(w_wr_sel & w_rd_sel));

  always_comb begin
    w_state_nxt = r_state;
    s_sel_o     = '0;
    s_we_o      = 1'b0;
    s_addr_o    = '0;
    s_wdata_o   = '0;
    rib_hold_o  = 1'b0;
    bus_err_o   = 1'b0;
    dbg_ack_o   = 1'b0;
    w_rd_issue  = 1'b0;
    w_dbg_grant = 1'b0;
    case (r_state)
      S_CORE: begin
        rib_hold_o = w_conflict;
        w_rd_issue = w_rd_vld & ~w_conflict;
        // The shared address/data bus carries the write when there is one;
        // a concurrent read only contributes its slave select.
        if (w_wr_vld) begin
          s_sel_o   = w_wr_sel;
          s_we_o    = ~w_wr_unm;
          s_addr_o  = core_wr_addr_i;
          s_wdata_o = core_wr_data_i;
        end else if (w_rd_issue) begin
          s_addr_o  = core_rd_addr_i;
        end
        if (w_rd_issue) begin
          s_sel_o = s_sel_o | w_rd_sel;
        end
        bus_err_o = (w_wr_vld & w_wr_unm) | (w_rd_issue & w_rd_unm);
        if (dbg_req_i && !w_wr_vld) begin
          w_dbg_grant = 1'b1;
          w_state_nxt = S_DBG;
        end
      end
      S_DBG: begin
        rib_hold_o  = 1'b1;
        s_sel_o     = r_dbg_sel;
        s_we_o      = r_dbg_we & ~r_dbg_unm;
        s_addr_o    = r_dbg_addr;
        s_wdata_o   = r_dbg_wdata;
        bus_err_o   = r_dbg_unm;
        w_state_nxt = S_DBG_RSP;
      end
      S_DBG_RSP: begin
        rib_hold_o  = 1'b1;
        dbg_ack_o   = 1'b1;
        w_state_nxt = S_CORE;
      end
      default: begin
        w_state_nxt = S_CORE;
      end
    endcase
  end

  // Read-return muxes; a zero select (unmapped) yields zero data.
  always_comb begin
    w_rd_data  = '0;
    w_dbg_data = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_rd_sel[i])  w_rd_data  = w_rd_data  | s_rdata_i[i*INST_DATA_BUS +: INST_DATA_BUS];
      if (r_dbg_sel[i]) w_dbg_data = w_dbg_data | s_rdata_i[i*INST_DATA_BUS +: INST_DATA_BUS];
    end
  end

  assign core_rd_data_o = r_rd_vld ? w_rd_data : r_rd_last;
  assign dbg_rdata_o    = (r_state == S_DBG_RSP && !r_dbg_we) ? w_dbg_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_CORE;
      r_rd_vld    <= 1'b0;
      r_rd_sel    <= '0;
      r_rd_last   <= '0;
      r_dbg_we    <= 1'b0;
      r_dbg_unm   <= 1'b0;
      r_dbg_sel   <= '0;
      r_dbg_addr  <= '0;
      r_dbg_wdata <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_vld  <= w_rd_issue;
      r_rd_sel  <= w_rd_issue ? w_rd_sel : '0;
      r_rd_last <= core_rd_data_o;
      if (w_dbg_grant) begin
        r_dbg_we    <= dbg_we_i;
        r_dbg_unm   <= w_dbg_unm;
        r_dbg_sel   <= w_dbg_sel;
        r_dbg_addr  <= dbg_addr_i;
        r_dbg_wdata <= dbg_wdata_i;
      end
    end
  end

endmodule
